div_arbiter: RTL and testbench

DIV_ARBITER -- requirements
Module: div_arbiter

---
 rtl/div_arbiter.sv | 155 +++++++++++++++
 tb/tb_div_arbiter.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/div_arbiter.sv
// Round-robin arbiter for a shared event-divider counter.
//
// Each requester asks for the counter with a level request and supplies a
// divide ratio N. The granted channel has its ratio latched. The arbiter then
// counts N cycles with in=1 and pulses done to that channel for one cycle.
// Dropping the request while the job runs abandons it without a done pulse.
// After a completion or an abandon, the round-robin pointer moves just past
// the channel that was served.
//
// Handshake: req[i] is a level. A channel holds it high until done[i] pulses
// or until it gives up by dropping it. gnt is one-hot and is valid while busy
// is high. done[i] is only ever high in the single DONE cycle, together with
// gnt[i].
module div_arbiter #(
    parameter int NREQ   = 4,
    parameter int CWIDTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*CWIDTH-1:0]   ratio,
    input  logic                     in,
    output logic [NREQ-1:0]          gnt,
    output logic                     busy,
    output logic [NREQ-1:0]          done,
    output logic [CWIDTH-1:0]        count,
    output logic [1:0]               state_dbg
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam logic [PW-1:0]     PTR_LAST = PW'(NREQ - 1);
    localparam logic [PW-1:0]     PTR_ONE  = PW'(1);
    localparam logic [CWIDTH-1:0] CNT_ONE  = CWIDTH'(1);
    localparam logic [NREQ-1:0]   GNT_ONE  = NREQ'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [NREQ-1:0]     gnt_q, gnt_d;
    logic [PW-1:0]       gidx_q, gidx_d;
    logic [PW-1:0]       ptr_q, ptr_d;
    logic [CWIDTH-1:0]   cnt_q, cnt_d;
    logic [CWIDTH-1:0]   nreg_q, nreg_d;

    logic                pick_vld;
    logic [PW-1:0]       pick_idx;
    logic [PW-1:0]       ptr_after_g;

    // Find the first requesting channel at or after ptr, wrapping around.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            int k;
            k = (int'(ptr_q) + i) % NREQ;
            if (!pick_vld && req[k]) begin
                pick_vld = 1'b1;
                pick_idx = k[PW-1:0];
            end
        end
    end

    // The pointer position just past the current grant holder. NREQ may be
    // any value from 2 to 8, so the wrap is explicit rather than a modulo.
    always_comb begin
        ptr_after_g = (gidx_q == PTR_LAST) ? '0 : gidx_q + PTR_ONE;
    end

    // State registers. The reset is asynchronous and clears everything, so an
    // aborted job leaves no done pulse and the pointer starts again at 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            gnt_q   <= '0;
            gidx_q  <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            nreg_q  <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            gidx_q  <= gidx_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            nreg_q  <= nreg_d;
        end
    end

    // Next-state logic: grant in IDLE, count in RUN, release in DONE.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        gidx_d  = gidx_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        nreg_d  = nreg_q;

        case (state_q)
            S_IDLE: begin
                gnt_d = '0;
                if (pick_vld) begin
                    gidx_d  = pick_idx;
                    gnt_d   = GNT_ONE << pick_idx;
                    nreg_d  = ratio[pick_idx*CWIDTH +: CWIDTH];
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end

            S_RUN: begin
                // An abandon wins over a completion in the same cycle.
                if (!req[gidx_q]) begin
                    state_d = S_IDLE;
                    gnt_d   = '0;
                    ptr_d   = ptr_after_g;
                end else if (nreg_q == '0) begin
                    // Ratio 0 is a degenerate job that consumes no events.
                    state_d = S_DONE;
                end else if (in) begin
                    cnt_d = cnt_q + CNT_ONE;
                    if (cnt_q == nreg_q - CNT_ONE) begin
                        state_d = S_DONE;
                    end
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
                gnt_d   = '0;
                ptr_d   = ptr_after_g;
            end

            default: begin
                state_d = S_IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    // Outputs come straight from the registers. done is gated by the
    // registered DONE state, so it can only reach the channel holding gnt.
    always_comb begin
        gnt       = gnt_q;
        busy      = (state_q == S_RUN) || (state_q == S_DONE);
        done      = (state_q == S_DONE) ? gnt_q : '0;
        count     = cnt_q;
        state_dbg = state_q;
    end

endmodule

// File: tb/tb_div_arbiter.sv
// Directed bench for div_arbiter with NREQ=4 and CWIDTH=4.
module tb_div_arbiter;

    localparam int NREQ   = 4;
    localparam int CWIDTH = 4;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic                   clk   = 1'b0;
    logic                   rst_n = 1'b0;
    logic [NREQ-1:0]        req   = '0;
    logic [NREQ*CWIDTH-1:0] ratio = '0;
    logic                   in    = 1'b0;

    logic [NREQ-1:0]        gnt;
    logic                   busy;
    logic [NREQ-1:0]        done;
    logic [CWIDTH-1:0]      count;
    logic [1:0]             state_dbg;

    int checks = 0;
    int errors = 0;

    div_arbiter #(.NREQ(NREQ), .CWIDTH(CWIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .ratio     (ratio),
        .in        (in),
        .gnt       (gnt),
        .busy      (busy),
        .done      (done),
        .count     (count),
        .state_dbg (state_dbg)
    );

    // Clock: 10 ns period, first rising edge at 5 ns.
    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 ns past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic exp_all(input string tag, input logic [3:0] g, input logic [3:0] d,
                           input logic [3:0] c, input logic b, input logic [1:0] s);
        chk({tag, ".gnt"},   32'(gnt),       32'(g));
        chk({tag, ".done"},  32'(done),      32'(d));
        chk({tag, ".count"}, 32'(count),     32'(c));
        chk({tag, ".busy"},  32'(busy),      32'(b));
        chk({tag, ".state"}, 32'(state_dbg), 32'(s));
    endtask

    initial begin
        // Reset state, before any clock edge.
        #3;
        exp_all("reset", 4'b0000, 4'b0000, 4'd0, 1'b0, S_IDLE);
        #9 rst_n = 1'b1;               // released at 12 ns, between edges

        // All four requesting, all ratios 1, in held high: grants 0,1,2,3,0
        // in turn, each job taking IDLE, RUN and DONE.
        #4;
        req   = 4'b1111;
        ratio = 16'h1111;
        in    = 1'b1;
        for (int j = 0; j < 5; j++) begin
            logic [3:0] g;
            g = 4'b0001 << (j % 4);
            tick();
            exp_all($sformatf("rr%0d.run", j), g, 4'b0000, 4'd0, 1'b1, S_RUN);
            tick();
            exp_all($sformatf("rr%0d.done", j), g, g, 4'd1, 1'b1, S_DONE);
            if (j == 4) req = 4'b0000;
            tick();
            // in stays high in IDLE and the count must not move.
            exp_all($sformatf("rr%0d.idle", j), 4'b0000, 4'b0000, 4'd1, 1'b0, S_IDLE);
        end

        // Channel 0, ratio 3, three spaced pulses (pointer now at 1).
        in    = 1'b0;
        ratio = 16'h0003;
        req   = 4'b0001;
        tick();
        exp_all("r3.grant", 4'b0001, 4'b0000, 4'd0, 1'b1, S_RUN);
        tick();
        exp_all("r3.hold0", 4'b0001, 4'b0000, 4'd0, 1'b1, S_RUN);
        in = 1'b1; tick();
        exp_all("r3.p1", 4'b0001, 4'b0000, 4'd1, 1'b1, S_RUN);
        in = 1'b0; tick();
        exp_all("r3.hold1", 4'b0001, 4'b0000, 4'd1, 1'b1, S_RUN);
        in = 1'b1; tick();
        exp_all("r3.p2", 4'b0001, 4'b0000, 4'd2, 1'b1, S_RUN);
        in = 1'b0; tick();
        exp_all("r3.hold2", 4'b0001, 4'b0000, 4'd2, 1'b1, S_RUN);
        in = 1'b1; tick();
        exp_all("r3.p3", 4'b0001, 4'b0001, 4'd3, 1'b1, S_DONE);
        in = 1'b0; req = 4'b0000; tick();
        exp_all("r3.idle", 4'b0000, 4'b0000, 4'd3, 1'b0, S_IDLE);

        // Channel 2 with ratio 0 completes without any in pulse.
        req = 4'b0100;
        tick();
        exp_all("r0.grant", 4'b0100, 4'b0000, 4'd0, 1'b1, S_RUN);
        tick();
        exp_all("r0.done", 4'b0100, 4'b0100, 4'd0, 1'b1, S_DONE);
        req = 4'b0000; tick();
        exp_all("r0.idle", 4'b0000, 4'b0000, 4'd0, 1'b0, S_IDLE);

        // Pointer is at 3, so with req=0011 channel 0 wins. Its ratio is 5.
        // A ratio change to 1 mid-run must be ignored. Abandoning after two
        // pulses then hands the counter to channel 1.
        ratio = 16'h0005;
        req   = 4'b0011;
        tick();
        exp_all("ab.grant0", 4'b0001, 4'b0000, 4'd0, 1'b1, S_RUN);
        ratio = 16'h0001;
        in    = 1'b1; tick();
        exp_all("ab.p1", 4'b0001, 4'b0000, 4'd1, 1'b1, S_RUN);
        tick();
        exp_all("ab.p2", 4'b0001, 4'b0000, 4'd2, 1'b1, S_RUN);
        in = 1'b0; req = 4'b0010; tick();
        exp_all("ab.drop", 4'b0000, 4'b0000, 4'd2, 1'b0, S_IDLE);
        tick();
        exp_all("ab.grant1", 4'b0010, 4'b0000, 4'd0, 1'b1, S_RUN);
        tick();   // ratio1 is 0 in 16'h0001
        exp_all("ab.done1", 4'b0010, 4'b0010, 4'd0, 1'b1, S_DONE);
        req = 4'b0000; tick();
        exp_all("ab.idle", 4'b0000, 4'b0000, 4'd0, 1'b0, S_IDLE);

        // Channel 2, ratio 2. The final pulse arrives together with the
        // request falling, which resolves as an abandon.
        ratio = 16'h0200;
        req   = 4'b0100;
        tick();
        exp_all("sc.grant", 4'b0100, 4'b0000, 4'd0, 1'b1, S_RUN);
        in = 1'b1; tick();
        exp_all("sc.p1", 4'b0100, 4'b0000, 4'd1, 1'b1, S_RUN);
        req = 4'b0000; tick();
        chk("sc.gnt",   32'(gnt),       32'(4'b0000));
        chk("sc.done",  32'(done),      32'(4'b0000));
        chk("sc.busy",  32'(busy),      32'(1'b0));
        chk("sc.state", 32'(state_dbg), 32'(S_IDLE));
        in = 1'b0; tick();
        chk("sc.nodone", 32'(done), 32'(4'b0000));

        // Asynchronous reset in the middle of a run, between clock edges.
        ratio = 16'h0004;
        req   = 4'b0001;
        tick();
        exp_all("rs.grant", 4'b0001, 4'b0000, 4'd0, 1'b1, S_RUN);
        in = 1'b1; tick();
        exp_all("rs.p1", 4'b0001, 4'b0000, 4'd1, 1'b1, S_RUN);
        #2 rst_n = 1'b0;
        #1;
        exp_all("rs.async", 4'b0000, 4'b0000, 4'd0, 1'b0, S_IDLE);
        in  = 1'b0;
        req = 4'b1000;
        #3 rst_n = 1'b1;
        tick();
        exp_all("rs.grant3", 4'b1000, 4'b0000, 4'd0, 1'b1, S_RUN);
        tick();   // ratio3 is 0 in 16'h0004
        exp_all("rs.done3", 4'b1000, 4'b1000, 4'd0, 1'b1, S_DONE);
        req = 4'b0000; tick();
        exp_all("rs.idle", 4'b0000, 4'b0000, 4'd0, 1'b0, S_IDLE);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
